// File: rtl/ppu_frame_signature.sv
// ppu_frame_signature
// Per-frame self-check for the PPU pixel stream. For every complete active
// frame it computes a CRC-32/BZIP2 signature and checks the frame geometry.
// It compares the signature against an expected value and keeps sticky error
// flags, so long board regressions can check themselves.
module ppu_frame_signature #(
    parameter int PIX_W    = 6,
    parameter int H_ACTIVE = 256,
    parameter int V_ACTIVE = 240,
    parameter int FCNT_W   = 16
) (
    input  logic              Clk,
    input  logic              reset_rtl_0_n,
    input  logic              enable,
    input  logic              clear,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic              pix_sol,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              exp_valid,
    input  logic [31:0]       exp_crc,
    output logic [31:0]       crc_out,
    output logic              crc_valid,
    output logic [FCNT_W-1:0] frame_count,
    output logic              mismatch,
    output logic              geom_err
);

    localparam int HCW = $clog2(H_ACTIVE + 1);
    localparam int VCW = $clog2(V_ACTIVE + 1);
    localparam logic [HCW-1:0] H_MAX  = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] H_PEN  = HCW'(H_ACTIVE - 1);
    localparam logic [VCW-1:0] V_LAST = VCW'(V_ACTIVE - 1);
    localparam logic [31:0]    CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0]    CRC_POLY = 32'h04C1_1DB7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // This function performs an MSB-first, non-reflected CRC-32 update over one byte.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] d);
        logic [31:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0};
            if (fb) begin
                c = c ^ CRC_POLY;
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

    state_t            state_r, state_nx_s;
    logic [31:0]       crc_r;
    logic [HCW-1:0]    hcnt_r;
    logic [VCW-1:0]    vcnt_r;
    logic [31:0]       crc_out_r;
    logic              crc_valid_r;
    logic [FCNT_W-1:0] frame_count_r;
    logic              mismatch_r;
    logic              geom_err_r;

    logic [7:0]        pix_byte_s;
    logic [31:0]       crc_next_s;
    logic              px_s;
    logic              start_s;
    logic              line_ok_s;
    logic              step_s;
    logic              last_s;
    logic              err_s;
    logic              done_s;

    assign px_s       = pix_valid & enable;
    assign pix_byte_s = 8'(pix_data);
    assign crc_next_s = crc32_byte(crc_r, pix_byte_s);

    // The state register is cleared asynchronously, and any frame in progress is dropped.
    always_ff @(posedge Clk or negedge reset_rtl_0_n) begin
        if (!reset_rtl_0_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state selection. Dropping enable always returns to IDLE.
    always_comb begin
        state_nx_s = state_r;
        if (!enable) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:     state_nx_s = ST_WAIT_SOF;
                ST_WAIT_SOF: begin
                    if (start_s) begin
                        state_nx_s = ST_ACTIVE;
                    end else begin
                        state_nx_s = ST_WAIT_SOF;
                    end
                end
                ST_ACTIVE: begin
                    if (err_s) begin
                        state_nx_s = ST_WAIT_SOF;
                    end else if (last_s) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_ACTIVE;
                    end
                end
                ST_DONE:     state_nx_s = ST_WAIT_SOF;
                default:     state_nx_s = ST_IDLE;
            endcase
        end
    end

    // Per-pixel decode. A pix_sof seen in ACTIVE counts as an error, so it never starts a new frame.
    always_comb begin
        start_s   = 1'b0;
        line_ok_s = 1'b0;
        step_s    = 1'b0;
        last_s    = 1'b0;
        err_s     = 1'b0;
        done_s    = 1'b0;
        case (state_r)
            ST_WAIT_SOF: begin
                start_s = px_s & pix_sof;
            end
            ST_ACTIVE: begin
                if (px_s) begin
                    err_s     = pix_sof | (pix_sol & (hcnt_r != H_MAX)) |
                                (~pix_sol & (hcnt_r == H_MAX));
                    line_ok_s = ~pix_sof & pix_sol & (hcnt_r == H_MAX);
                    step_s    = ~pix_sof & ~pix_sol & (hcnt_r != H_MAX);
                    last_s    = ~pix_sof & ~pix_sol & (hcnt_r == H_PEN) & (vcnt_r == V_LAST);
                end else begin
                    err_s = 1'b0;
                end
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                start_s = 1'b0;
            end
        endcase
    end

    // Running CRC and the line/pixel counters for the frame in progress.
    always_ff @(posedge Clk or negedge reset_rtl_0_n) begin
        if (!reset_rtl_0_n) begin
            crc_r  <= CRC_INIT;
            hcnt_r <= {HCW{1'b0}};
            vcnt_r <= {VCW{1'b0}};
        end else if (start_s) begin
            crc_r  <= crc32_byte(CRC_INIT, pix_byte_s);
            hcnt_r <= HCW'(1);
            vcnt_r <= {VCW{1'b0}};
        end else if (line_ok_s) begin
            crc_r  <= crc_next_s;
            hcnt_r <= HCW'(1);
            vcnt_r <= vcnt_r + VCW'(1);
        end else if (step_s) begin
            crc_r  <= crc_next_s;
            hcnt_r <= hcnt_r + HCW'(1);
            vcnt_r <= vcnt_r;
        end else begin
            crc_r  <= crc_r;
            hcnt_r <= hcnt_r;
            vcnt_r <= vcnt_r;
        end
    end

    // The signature is published on the same edge that accepts the last pixel, so it is visible in the DONE cycle.
    always_ff @(posedge Clk or negedge reset_rtl_0_n) begin
        if (!reset_rtl_0_n) begin
            crc_out_r   <= 32'h0000_0000;
            crc_valid_r <= 1'b0;
        end else if (last_s) begin
            crc_out_r   <= crc_next_s ^ CRC_INIT;
            crc_valid_r <= 1'b1;
        end else begin
            crc_out_r   <= crc_out_r;
            crc_valid_r <= 1'b0;
        end
    end

    // Sticky flags and the good-frame counter. When clear and a DONE update land in the same cycle, clear wins.
    always_ff @(posedge Clk or negedge reset_rtl_0_n) begin
        if (!reset_rtl_0_n) begin
            frame_count_r <= {FCNT_W{1'b0}};
            mismatch_r    <= 1'b0;
            geom_err_r    <= 1'b0;
        end else if (clear) begin
            frame_count_r <= {FCNT_W{1'b0}};
            mismatch_r    <= 1'b0;
            geom_err_r    <= 1'b0;
        end else begin
            geom_err_r <= geom_err_r | err_s;
            if (done_s) begin
                frame_count_r <= frame_count_r + FCNT_W'(1);
                mismatch_r    <= mismatch_r | (exp_valid & (crc_out_r != exp_crc));
            end else begin
                frame_count_r <= frame_count_r;
                mismatch_r    <= mismatch_r;
            end
        end
    end

    assign crc_out     = crc_out_r;
    assign crc_valid   = crc_valid_r;
    assign frame_count = frame_count_r;
    assign mismatch    = mismatch_r;
    assign geom_err    = geom_err_r;

endmodule

// File: tb/tb_ppu_frame_signature.sv
// Testbench for ppu_frame_signature. It uses two instances: dut1 (9x1 frames)
// and dut2 (9x2 frames). Each instance has its own enable, and they share
// every other input.
module tb_ppu_frame_signature;

    localparam int H = 9;

    logic        clk = 1'b0;
    logic        rst_n, en1, en2, clr, pv, psof, psol, expv;
    logic [7:0]  pd;
    logic [31:0] expc;

    logic [31:0] co1, co2;
    logic        cv1, cv2, mm1, mm2, ge1, ge2;
    logic [15:0] fc1, fc2;

    int tests = 0;
    int fails = 0;
    int nv1 = 0;
    int nv2 = 0;
    int base;
    logic [7:0] fbuf [0:17];

    always #5 clk = ~clk;

    ppu_frame_signature #(.PIX_W(8), .H_ACTIVE(9), .V_ACTIVE(1), .FCNT_W(16)) dut1 (
        .Clk(clk), .reset_rtl_0_n(rst_n), .enable(en1), .clear(clr),
        .pix_valid(pv), .pix_sof(psof), .pix_sol(psol), .pix_data(pd),
        .exp_valid(expv), .exp_crc(expc),
        .crc_out(co1), .crc_valid(cv1), .frame_count(fc1), .mismatch(mm1), .geom_err(ge1));

    ppu_frame_signature #(.PIX_W(8), .H_ACTIVE(9), .V_ACTIVE(2), .FCNT_W(16)) dut2 (
        .Clk(clk), .reset_rtl_0_n(rst_n), .enable(en2), .clear(clr),
        .pix_valid(pv), .pix_sof(psof), .pix_sol(psol), .pix_data(pd),
        .exp_valid(expv), .exp_crc(expc),
        .crc_out(co2), .crc_valid(cv2), .frame_count(fc2), .mismatch(mm2), .geom_err(ge2));

    // Count crc_valid pulses away from the active edge.
    always @(negedge clk) begin
        if (cv1 === 1'b1) nv1 <= nv1 + 1;
        if (cv2 === 1'b1) nv2 <= nv2 + 1;
    end

    // Reference CRC-32/BZIP2 computed bit by bit over the first n bytes of fbuf.
    function automatic logic [31:0] ref_crc(input int n);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFF_FFFF;
        for (int k = 0; k < n; k++) begin
            b = fbuf[k];
            for (int j = 7; j >= 0; j--) begin
                if ((c[31] ^ b[j]) == 1'b1) c = (c << 1) ^ 32'h04C1_1DB7;
                else                        c = c << 1;
            end
        end
        return ~c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic sof, input logic sol, input logic [7:0] d, input bit gaps);
        if (gaps) begin
            for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
                pv = 1'b0; psof = 1'($urandom); psol = 1'($urandom); pd = 8'($urandom);
                tick();
            end
        end
        pv = 1'b1; psof = sof; psol = sol; pd = d;
        tick();
        pv = 1'b0; psof = 1'b0; psol = 1'b0;
    endtask

    task automatic frame(input int first, input int n, input bit gaps);
        for (int i = first; i < n; i++) pix(i == 0, (i % H) == 0, fbuf[i], gaps);
    endtask

    task automatic fill_ascii();
        for (int i = 0; i < 9; i++) fbuf[i] = 8'h31 + 8'(i);
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) fbuf[i] = 8'($urandom);
    endtask

    initial begin
        rst_n = 1'b0; en1 = 1'b0; en2 = 1'b0; clr = 1'b0;
        pv = 1'b0; psof = 1'b0; psol = 1'b0; pd = 8'h00;
        expv = 1'b0; expc = 32'h0;
        tick(); tick();
        check("rst_crc_out", co1, 32'h0);
        check("rst_crc_valid", 32'(cv1), 32'h0);
        check("rst_frame_count", 32'(fc1), 32'h0);
        check("rst_mismatch", 32'(mm1), 32'h0);
        check("rst_geom_err", 32'(ge1), 32'h0);
        check("rst_crc_out2", co2, 32'h0);
        rst_n = 1'b1; en1 = 1'b1;
        tick();

        // Known vector "123456789"
        fill_ascii(); expv = 1'b1; expc = 32'hFC89_1918;
        frame(0, 9, 1'b0);
        check("t1_valid", 32'(cv1), 32'h1);
        check("t1_crc_const", co1, 32'hFC89_1918);
        check("t1_crc_model", co1, ref_crc(9));
        tick();
        check("t1_pulse_end", 32'(cv1), 32'h0);
        check("t1_fcount", 32'(fc1), 32'h1);
        check("t1_mismatch", 32'(mm1), 32'h0);

        // Wrong expected value sets a sticky mismatch; clear removes it
        expc = 32'h0;
        frame(0, 9, 1'b0); tick();
        check("t2_mismatch", 32'(mm1), 32'h1);
        check("t2_fcount", 32'(fc1), 32'h2);
        expc = 32'hFC89_1918;
        frame(0, 9, 1'b0); tick();
        check("t2_sticky", 32'(mm1), 32'h1);
        check("t2_fcount2", 32'(fc1), 32'h3);
        clr = 1'b1; tick(); clr = 1'b0;
        check("t2_clr_mm", 32'(mm1), 32'h0);
        check("t2_clr_fc", 32'(fc1), 32'h0);

        // Random frames with random gaps
        for (int k = 0; k < 4; k++) begin
            fill_rand(9); expc = ref_crc(9); expv = 1'($urandom);
            base = nv1;
            frame(0, 9, 1'b1);
            check("rnd_crc", co1, ref_crc(9));
            tick();
            check("rnd_pulses", 32'(nv1), 32'(base + 1));
            check("rnd_mismatch", 32'(mm1), 32'h0);
            check("rnd_fcount", 32'(fc1), 32'(k + 1));
        end

        // Gaps over the known vector do not change the result
        fill_ascii(); expv = 1'b1; expc = 32'hFC89_1918;
        frame(0, 9, 1'b1);
        check("t4_gap_crc", co1, 32'hFC89_1918);
        tick();

        // Back-to-back frame: a sof in the DONE cycle is ignored
        base = nv1;
        frame(0, 9, 1'b0);
        frame(0, 9, 1'b0);
        tick();
        check("b2b_pulses", 32'(nv1), 32'(base + 1));
        check("b2b_fcount", 32'(fc1), 32'h6);
        check("b2b_geom", 32'(ge1), 32'h0);

        // Dropping enable mid-frame discards the frame
        base = nv1;
        frame(0, 4, 1'b0);
        en1 = 1'b0; pix(1'b0, 1'b0, fbuf[4], 1'b0); en1 = 1'b1;
        frame(5, 9, 1'b0);
        tick();
        check("t6_no_valid", 32'(nv1), 32'(base));
        check("t6_geom", 32'(ge1), 32'h0);
        check("t6_fcount", 32'(fc1), 32'h6);
        frame(0, 9, 1'b0);
        check("t6_valid", 32'(cv1), 32'h1);
        check("t6_crc", co1, 32'hFC89_1918);
        tick();

        // Reset in the middle of a frame
        fill_rand(9);
        frame(0, 4, 1'b0);
        rst_n = 1'b0; #2;
        check("t5_rst_crc", co1, 32'h0);
        check("t5_rst_fc", 32'(fc1), 32'h0);
        check("t5_rst_valid", 32'(cv1), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        fill_rand(9); expc = ref_crc(9);
        base = nv1;
        frame(0, 9, 1'b0);
        check("t5_valid", 32'(cv1), 32'h1);
        check("t5_crc", co1, ref_crc(9));
        tick();
        check("t5_pulses", 32'(nv1), 32'(base + 1));
        check("t5_fcount", 32'(fc1), 32'h1);

        // Geometry checks on the two-line instance
        en1 = 1'b0; en2 = 1'b1; expv = 1'b0;
        tick();
        fill_rand(18);
        base = nv2;
        frame(0, 9, 1'b0);
        pix(1'b0, 1'b1, fbuf[9], 1'b0);
        for (int i = 10; i < 17; i++) pix(1'b0, 1'b0, fbuf[i], 1'b0);
        pix(1'b0, 1'b1, fbuf[17], 1'b0);
        tick();
        check("t3_geom", 32'(ge2), 32'h1);
        check("t3_no_valid", 32'(nv2), 32'(base));
        check("t3_fcount", 32'(fc2), 32'h0);
        frame(0, 18, 1'b1);
        check("t3_valid", 32'(cv2), 32'h1);
        check("t3_crc", co2, ref_crc(18));
        tick();
        check("t3_geom_sticky", 32'(ge2), 32'h1);
        check("t3_fcount2", 32'(fc2), 32'h1);
        clr = 1'b1; tick(); clr = 1'b0;
        check("t3_clr_geom", 32'(ge2), 32'h0);

        // A non-sol pixel after a full line
        frame(0, 9, 1'b0);
        pix(1'b0, 1'b0, 8'hA5, 1'b0);
        tick();
        check("long_line_geom", 32'(ge2), 32'h1);
        clr = 1'b1; tick(); clr = 1'b0;

        // A sof in ACTIVE is an error and does not start a new frame
        base = nv2;
        frame(0, 3, 1'b0);
        frame(0, 18, 1'b0);
        tick();
        check("sof_active_geom", 32'(ge2), 32'h1);
        check("sof_active_novalid", 32'(nv2), 32'(base));

        // When clear lands in the DONE cycle it wins, while crc_out still updates
        frame(0, 18, 1'b0);
        check("clr_done_valid", 32'(cv2), 32'h1);
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_done_fc", 32'(fc2), 32'h0);
        check("clr_done_geom", 32'(ge2), 32'h0);
        check("clr_done_crc", co2, ref_crc(18));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
